gtech_parity_accum: RTL
=======================

Name: gtech_parity_accum

Overview:
- Parametrised, streaming successor to the fixed 4-input XOR cell.
- Computes per-lane XOR parity over multi-beat frames of WIDTH-bit words split into LANES lanes, with valid/ready on input and output.
- Reports one registered parity vector plus beat count per frame.
- Sits between datapath stream sources and integrity checkers / link CRC-lite logic.

Parameters:
- WIDTH, 32, input word width in bits; must be a multiple of LANES.
- LANES, 4, number of independent parity lanes; lane i covers IN_DATA[i*LW +: LW], where LW = WIDTH/LANES.
- ODD, 0, 0 = even parity (XOR of bits), 1 = odd parity (XOR inverted per lane).
- CNT_W, 8, beat-counter width; the counter saturates.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN_VALID  input  1  input beat valid
- IN_READY  output  1  block can accept a beat
- IN_DATA  input  WIDTH  input word
- IN_LAST  input  1  final beat of frame
- OUT_VALID  output  1  frame result valid
- OUT_READY  input  1  consumer accepts result
- OUT_PAR  output  LANES  per-lane frame parity
- OUT_CNT  output  CNT_W  beats in frame, saturating
- EXP_PAR  input  LANES  expected parity, sampled on the last beat (only with GTECH_PARITY_CHECK_EN)
- OUT_ERR  output  1  mismatch flag (only with GTECH_PARITY_CHECK_EN)

Behaviour:
- Single clock CLK. Reset is asynchronous, active-low on RST_N.
- Reset values: OUT_VALID=0, OUT_PAR=0, OUT_CNT=0, OUT_ERR=0, internal acc=0, beat cnt=0, state=IDLE.
- Accept condition: a beat is accepted when IN_VALID & IN_READY.
- IN_READY = ~OUT_VALID | OUT_READY, combinational.
  - The output slot must be free, or draining this cycle, before a beat is taken.
  - IN_READY is low while a result is stalled.
- Lane XOR: lx[i] = ^IN_DATA[i*LW +: LW]. acc_next = acc ^ lx.
- FSM IDLE -> ACCUM on an accepted non-last beat.
- FSM ACCUM -> ACCUM on accepted non-last beats.
  - acc <= acc_next.
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
- Accepted last beat, from either state:
  - OUT_PAR <= acc_next ^ {LANES{ODD}}.
  - OUT_CNT <= sat(cnt+1).
  - OUT_VALID <= 1.
  - acc <= 0, cnt <= 0, state <= IDLE.
- Single-beat frame: a last beat accepted in IDLE yields OUT_CNT=1 and parity of that word alone.
- Latency: last beat accepted in cycle t gives OUT_VALID high in cycle t+1.
- OUT_VALID, OUT_PAR, OUT_CNT and OUT_ERR hold stable until OUT_READY is sampled high while OUT_VALID is high.
- After that handshake OUT_VALID clears, unless a new last beat is accepted in the same cycle. In that case OUT_VALID stays 1 and the new result loads. This gives back-to-back single-beat frames at one frame per cycle.
- No accepted beat: acc, cnt and state hold. IN_DATA is ignored when IN_VALID=0.
- Saturation: cnt stops at max and never wraps; parity keeps accumulating.
- Reset mid-frame or with a result pending: all state is dropped immediately; the partial frame is lost and no output is produced.
- X-safety: IN_DATA is not used unless the beat is accepted.

Optional Feature:
- Macro: GTECH_PARITY_CHECK_EN.
- Defined:
  - EXP_PAR and OUT_ERR ports exist.
  - On the accepted last beat, OUT_ERR <= |(acc_next ^ {LANES{ODD}} ^ EXP_PAR).
  - OUT_ERR is held and cleared with OUT_VALID; it is 0 from reset.
- Undefined:
  - Neither port exists and no compare logic is built.
  - All other behaviour is identical.

Test Plan (WIDTH=8, LANES=2, ODD=0, CNT_W=4 unless stated):
- Two-beat frame: 0x0F, then 0x01 with last, OUT_READY=1 -> one cycle after the last beat, OUT_VALID=1, OUT_PAR=2'b01, OUT_CNT=1 -> 2.
- ODD=1, single beat 0xFF with last -> OUT_PAR=2'b11, OUT_CNT=1.
- Backpressure: result pending with OUT_READY=0 for 5 cycles and IN_VALID=1 -> IN_READY=0 and outputs stable all 5 cycles. When OUT_READY rises, the next last beat loads in the same cycle and OUT_VALID stays 1.
- Saturation: frame of 20 beats of 0x01 -> OUT_CNT=15, OUT_PAR=2'b00 (20 ones in lane 0).
- Reset after 3 non-last beats of 0x10 -> all outputs 0. A following single beat 0x00 with last gives OUT_PAR=2'b00, OUT_CNT=1, with no residue of the earlier beats.
- Macro GTECH_PARITY_CHECK_EN: frame 0x0F, 0x01 with last:
  - EXP_PAR=2'b01 -> OUT_ERR=0.
  - EXP_PAR=2'b11 -> OUT_ERR=1.
  - OUT_ERR clears with the OUT_VALID handshake.

Source files
------------

// File: rtl/gtech_parity_accum.sv
// Streaming per-lane XOR parity over valid/ready frames; one registered result per frame.
// Define GTECH_PARITY_CHECK_EN to add the EXP_PAR compare port and the OUT_ERR flag.
module gtech_parity_accum #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int ODD   = 0,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [LANES-1:0] OUT_PAR,
  output logic [CNT_W-1:0] OUT_CNT
`ifdef GTECH_PARITY_CHECK_EN
  ,
  input  logic [LANES-1:0] EXP_PAR,
  output logic             OUT_ERR
`endif
);

  localparam int               LW       = WIDTH / LANES;
  localparam logic [LANES-1:0] ODD_MASK = (ODD != 0) ? {LANES{1'b1}} : {LANES{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  function automatic logic [LANES-1:0] lane_xor(input logic [WIDTH-1:0] data);
    logic [LANES-1:0] lx;
    lx = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      lx[i] = ^data[i*LW +: LW];
    end
    return lx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  state_e           state_q;
  logic [LANES-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [LANES-1:0] out_par_q;
  logic [CNT_W-1:0] out_cnt_q;
`ifdef GTECH_PARITY_CHECK_EN
  logic             out_err_q;
`endif

  logic             accept_s;
  logic [LANES-1:0] lane_x_s;
  logic [LANES-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;

  assign IN_READY  = ~out_valid_q | OUT_READY;
  assign OUT_VALID = out_valid_q;
  assign OUT_PAR   = out_par_q;
  assign OUT_CNT   = out_cnt_q;
`ifdef GTECH_PARITY_CHECK_EN
  assign OUT_ERR   = out_err_q;
`endif

  // Data is gated by the accept so an idle, possibly-X bus never reaches the accumulator.
  always_comb begin
    accept_s = IN_VALID & IN_READY;
    lane_x_s = accept_s ? lane_xor(IN_DATA) : {LANES{1'b0}};
    acc_d    = acc_q ^ lane_x_s;
    cnt_d    = sat_inc(cnt_q);
  end

  // Frame FSM, accumulator and the output result slot.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      acc_q       <= {LANES{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_par_q   <= {LANES{1'b0}};
      out_cnt_q   <= {CNT_W{1'b0}};
`ifdef GTECH_PARITY_CHECK_EN
      out_err_q   <= 1'b0;
`endif
    end else begin
      if (out_valid_q && OUT_READY) begin
        out_valid_q <= 1'b0;
`ifdef GTECH_PARITY_CHECK_EN
        out_err_q   <= 1'b0;
`endif
      end
      // A last beat loads the slot in the same cycle it drains, keeping one frame per cycle.
      if (accept_s && IN_LAST) begin
        out_valid_q <= 1'b1;
        out_par_q   <= acc_d ^ ODD_MASK;
        out_cnt_q   <= cnt_d;
`ifdef GTECH_PARITY_CHECK_EN
        out_err_q   <= |(acc_d ^ ODD_MASK ^ EXP_PAR);
`endif
        acc_q       <= {LANES{1'b0}};
        cnt_q       <= {CNT_W{1'b0}};
        state_q     <= IDLE;
      end else if (accept_s) begin
        case (state_q)
          IDLE: begin
            acc_q   <= lane_x_s;
            cnt_q   <= CNT_W'(1);
            state_q <= ACCUM;
          end
          ACCUM: begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            state_q <= ACCUM;
          end
          default: begin
            acc_q   <= {LANES{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= IDLE;
          end
        endcase
      end else begin
        acc_q   <= acc_q;
        cnt_q   <= cnt_q;
        state_q <= state_q;
      end
    end
  end

endmodule
